// File: rtl/ili9341_pixel_streamer.sv
// ili9341_pixel_streamer
// Buffers RGB565 pixels written by the CPU and streams them to the ILI9341 parallel driver
// over a level handshake (pix_clk / reset_cursor requests against lcd_busy). Counts delivered
// pixels per frame, pulses frame_done at wrap and homes the cursor on frame_start.
//
// Ports:
//   clk_16MHz, reset        clock, synchronous active-high reset
//   wr_en, wr_data          pixel push into the FIFO
//   fifo_full, fifo_level   FIFO occupancy
//   overflow, clr_overflow  sticky drop flag (write while full) and its clear
//   frame_start             request a cursor home and counter restart
//   frame_done              1-cycle pulse when the pixel counter wraps
//   active                  transfer in flight, data queued, or home pending
//   pix_data, pix_clk       pixel and request level to the driver
//   reset_cursor            cursor-home request level to the driver
//   lcd_busy                driver busy
//
// Optional feature, enabled by defining ILI9341_STREAMER_FILL_EN:
//   fill_start, fill_color  stream FRAME_PIXELS copies of fill_color after a home sequence

module ili9341_pixel_streamer #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned FRAME_PIXELS = 76800
) (
  input  logic                        clk_16MHz,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [15:0]                 wr_data,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clr_overflow,
  input  logic                        frame_start,
  output logic                        frame_done,
  output logic                        active,
  output logic [15:0]                 pix_data,
  output logic                        pix_clk,
  output logic                        reset_cursor,
`ifdef ILI9341_STREAMER_FILL_EN
  input  logic                        fill_start,
  input  logic [15:0]                 fill_color,
`endif
  input  logic                        lcd_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FRAME_PIXELS);
  localparam logic [AW:0]   FullLevel = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LastPix   = CW'(FRAME_PIXELS - 1);

  typedef enum logic [2:0] {StIdle, StPixReq, StPixHold, StHomeReq, StHomeHold} state_e;

  state_e        state_q, state_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          overflow_q, overflow_d;
  logic          home_pending_q, home_pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic          frame_done_q, frame_done_d;
  logic          push, pop, fifo_empty;
  logic          fill_q;
  logic [15:0]   fill_pix;

`ifdef ILI9341_STREAMER_FILL_EN
  logic          fill_d;
  logic [15:0]   fill_color_q, fill_color_d;
  assign fill_pix = fill_color_q;
`else
  assign fill_q   = 1'b0;
  assign fill_pix = 16'h0000;
`endif

  assign fifo_full  = (level_q == FullLevel);
  assign fifo_empty = (level_q == '0);
  assign push       = wr_en && !fifo_full;

  always_comb begin
    state_d        = state_q;
    pix_data_d     = pix_data_q;
    cnt_d          = cnt_q;
    frame_done_d   = 1'b0;
    home_pending_d = home_pending_q;
    pop            = 1'b0;
`ifdef ILI9341_STREAMER_FILL_EN
    fill_d         = fill_q;
    fill_color_d   = fill_color_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef ILI9341_STREAMER_FILL_EN
        // A fill always starts from a homed cursor, so it just queues a home first.
        if (fill_start && !fill_q) begin
          fill_d         = 1'b1;
          fill_color_d   = fill_color;
          home_pending_d = 1'b1;
        end else
`endif
        if (home_pending_q && !lcd_busy) begin
          state_d = StHomeReq;
        end else if (fill_q && !lcd_busy) begin
          pix_data_d = fill_pix;
          state_d    = StPixReq;
        end else if (!fifo_empty && !lcd_busy) begin
          pix_data_d = mem_q[rd_ptr_q];
          state_d    = StPixReq;
        end
      end
      StPixReq: begin
        if (lcd_busy) state_d = StPixHold;
      end
      StPixHold: begin
        if (!lcd_busy) begin
          pop = !fill_q;
          if (cnt_q == LastPix) begin
            cnt_d        = '0;
            frame_done_d = 1'b1;
`ifdef ILI9341_STREAMER_FILL_EN
            fill_d       = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          state_d = StIdle;
        end
      end
      StHomeReq: begin
        if (lcd_busy) state_d = StHomeHold;
      end
      StHomeHold: begin
        if (!lcd_busy) begin
          home_pending_d = 1'b0;
          cnt_d          = '0;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A new request outranks the clear of the one just served.
    if (frame_start) home_pending_d = 1'b1;
    // Set wins over clear.
    if (wr_en && fifo_full)  overflow_d = 1'b1;
    else if (clr_overflow)   overflow_d = 1'b0;
    else                     overflow_d = overflow_q;
  end

  always_ff @(posedge clk_16MHz) begin
    if (reset) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      overflow_q     <= 1'b0;
      home_pending_q <= 1'b0;
      cnt_q          <= '0;
      pix_data_q     <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      overflow_q     <= overflow_d;
      home_pending_q <= home_pending_d;
      cnt_q          <= cnt_d;
      pix_data_q     <= pix_data_d;
      frame_done_q   <= frame_done_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef ILI9341_STREAMER_FILL_EN
  always_ff @(posedge clk_16MHz) begin
    if (reset) begin
      fill_q       <= 1'b0;
      fill_color_q <= '0;
    end else begin
      fill_q       <= fill_d;
      fill_color_q <= fill_color_d;
    end
  end
`endif

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk_16MHz) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Requests are decoded from the registered state, so they are glitch-free levels.
  assign pix_clk      = (state_q == StPixReq);
  assign reset_cursor = (state_q == StHomeReq);
  assign pix_data     = pix_data_q;
  assign frame_done   = frame_done_q;
  assign overflow     = overflow_q;
  assign fifo_level   = level_q;
  assign active       = (state_q != StIdle) || !fifo_empty || home_pending_q || fill_q;

endmodule

// File: tb/tb_ili9341_pixel_streamer.sv
// Self-checking bench for ili9341_pixel_streamer (FIFO_DEPTH=16, FRAME_PIXELS=4).
// A behavioural LCD driver answers requests and logs every event (pixel, home, frame_done);
// the log is compared against an expected event list built from a queue model.

module tb_ili9341_pixel_streamer;

  localparam int unsigned Depth    = 16;
  localparam int unsigned FramePix = 4;
  localparam logic [17:0] EvHome   = 18'h10000;
  localparam logic [17:0] EvDone   = 18'h20000;

  logic        clk_16MHz;
  logic        reset, wr_en, clr_overflow, frame_start, lcd_busy;
  logic [15:0] wr_data;
  logic        fifo_full, overflow, frame_done, active, pix_clk, reset_cursor;
  logic [4:0]  fifo_level;
  logic [15:0] pix_data;
`ifdef ILI9341_STREAMER_FILL_EN
  logic        fill_start;
  logic [15:0] fill_color;
`endif

  ili9341_pixel_streamer #(
    .FIFO_DEPTH  (Depth),
    .FRAME_PIXELS(FramePix)
  ) dut (
    .clk_16MHz   (clk_16MHz),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .fifo_full   (fifo_full),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .clr_overflow(clr_overflow),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .active      (active),
    .pix_data    (pix_data),
    .pix_clk     (pix_clk),
    .reset_cursor(reset_cursor),
`ifdef ILI9341_STREAMER_FILL_EN
    .fill_start  (fill_start),
    .fill_color  (fill_color),
`endif
    .lcd_busy    (lcd_busy)
  );

  initial begin
    clk_16MHz = 1'b0;
    forever #5 clk_16MHz = ~clk_16MHz;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural LCD driver ----------------
  int          drv_busy_len = 0;   // 0: random 1..3 cycles
  int          drv_gap_len  = -1;  // -1: random 0..2 cycles
  bit          drv_hold     = 0;   // driver initialising: busy held high
  bit          drv_mute     = 0;   // ignore requests entirely
  logic [17:0] obs_q[$];

  initial begin
    int          busy_left;
    int          gap_left;
    logic [15:0] cap;
    bit          is_pix;
    busy_left = 0;
    gap_left  = 0;
    cap       = '0;
    is_pix    = 0;
    lcd_busy  = 1'b0;
    forever begin
      @(negedge clk_16MHz);
      if (frame_done === 1'b1) obs_q.push_back(EvDone);
      if (busy_left > 0) begin
        chk("req_drop", {pix_clk, reset_cursor}, 0);
        if (is_pix) chk("pix_data_hold", pix_data, cap);
        busy_left--;
        if (busy_left == 0) begin
          lcd_busy = 1'b0;
          gap_left = (drv_gap_len < 0) ? int'($urandom_range(0, 2)) : drv_gap_len;
        end
      end else if (gap_left > 0) begin
        gap_left--;
      end else if (drv_hold) begin
        lcd_busy = 1'b1;
      end else begin
        lcd_busy = 1'b0;
        if (!drv_mute && pix_clk === 1'b1) begin
          obs_q.push_back({2'b00, pix_data});
          cap       = pix_data;
          is_pix    = 1;
          lcd_busy  = 1'b1;
          busy_left = (drv_busy_len == 0) ? int'($urandom_range(1, 3)) : drv_busy_len;
        end else if (!drv_mute && reset_cursor === 1'b1) begin
          obs_q.push_back(EvHome);
          is_pix    = 0;
          lcd_busy  = 1'b1;
          busy_left = (drv_busy_len == 0) ? int'($urandom_range(1, 3)) : drv_busy_len;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] m_fifo[$];
  int          m_cnt = 0;
  logic [17:0] exp_q[$];

  function automatic void emit_done_if_wrap();
    m_cnt++;
    if (m_cnt == FramePix) begin
      m_cnt = 0;
      exp_q.push_back(EvDone);
    end
  endfunction

  function automatic void emit_pixel();
    exp_q.push_back({2'b00, m_fifo.pop_front()});
    emit_done_if_wrap();
  endfunction

  function automatic void emit_home();
    exp_q.push_back(EvHome);
    m_cnt = 0;
  endfunction

  task automatic push(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk_16MHz);
    wr_en   = 1'b0;
    if (m_fifo.size() < Depth) m_fifo.push_back(d);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(negedge clk_16MHz);
    frame_start = 1'b0;
  endtask

  // Queue everything still in the model, wait for the DUT to go quiet, compare event logs.
  task automatic drain(input string tag);
    int          t;
    logic [31:0] got;
    t = 0;
    while (m_fifo.size() > 0) emit_pixel();
    do begin
      @(negedge clk_16MHz);
      t++;
    end while ((active === 1'b1 || lcd_busy === 1'b1) && t < 2000);
    repeat (4) @(negedge clk_16MHz);
    chk({tag, " quiet_in_time"}, 32'(t < 2000), 1);
    chk({tag, " event_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF_FFFF;
      chk($sformatf("%s event[%0d]", tag, i), got, 32'(exp_q[i]));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    reset        = 1'b1;
    wr_en        = 1'b0;
    wr_data      = '0;
    clr_overflow = 1'b0;
    frame_start  = 1'b0;
`ifdef ILI9341_STREAMER_FILL_EN
    fill_start   = 1'b0;
    fill_color   = '0;
`endif
    repeat (3) @(negedge clk_16MHz);
    chk("rst pix_clk", pix_clk, 0);
    chk("rst reset_cursor", reset_cursor, 0);
    chk("rst pix_data", pix_data, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst overflow", overflow, 0);
    chk("rst fifo_level", fifo_level, 0);
    chk("rst fifo_full", fifo_full, 0);
    chk("rst active", active, 0);
    reset = 1'b0;
    @(negedge clk_16MHz);

    // Handshake and latency: busy 1 cycle, then low 3 cycles.
    drv_busy_len = 1;
    drv_gap_len  = 3;
    push(16'hF800);
    chk("lat pix_clk c1", pix_clk, 0);
    chk("lat level c1", fifo_level, 1);
    @(negedge clk_16MHz);
    chk("lat pix_clk c2", pix_clk, 1);
    chk("lat pix_data", pix_data, 16'hF800);
    chk("lat level c2", fifo_level, 1);
    drain("handshake");
    chk("handshake level", fifo_level, 0);
    drv_busy_len = 0;
    drv_gap_len  = -1;

    // Ordering and overflow with the driver still initialising.
    drv_hold = 1;
    @(negedge clk_16MHz);
    for (int i = 1; i <= 16; i++) push(16'(i));
    chk("order full", fifo_full, 1);
    chk("order level", fifo_level, 16);
    chk("order no_ovf", overflow, 0);
    chk("order idle", pix_clk, 0);
    push(16'hDEAD);
    chk("order ovf set", overflow, 1);
    chk("order level kept", fifo_level, 16);
    clr_overflow = 1'b0;
    overflow_clear_race();
    chk("ovf set_wins", overflow, 1);
    clr_overflow = 1'b1;
    @(negedge clk_16MHz);
    clr_overflow = 1'b0;
    chk("ovf cleared", overflow, 0);
    drv_hold = 0;
    drain("order");

    // frame_start while a pixel is in flight with 3 more queued.
    drv_hold = 1;
    @(negedge clk_16MHz);
    for (int i = 0; i < 4; i++) push(16'($urandom));
    drv_busy_len = 4;
    drv_hold     = 0;
    t = 0;
    while (obs_q.size() == 0 && t < 200) begin
      @(negedge clk_16MHz);
      t++;
    end
    chk("home req_seen", 32'(t < 200), 1);
    pulse_frame_start();
    emit_pixel();
    emit_home();
    drain("home");
    drv_busy_len = 0;

    // Home from idle, then a 9-pixel stream: frame_done after pixels 4 and 8.
    pulse_frame_start();
    emit_home();
    drain("home_idle");
    for (int i = 0; i < 9; i++) push(16'($urandom));
    drain("wrap");

    // Random bursts with random spacing.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        push(16'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk_16MHz);
      end
      drain($sformatf("burst%0d", r));
    end

`ifdef ILI9341_STREAMER_FILL_EN
    // Fill: one home, FRAME_PIXELS copies, frame_done, queued pixels untouched until after.
    drv_hold = 1;
    @(negedge clk_16MHz);
    push(16'($urandom));
    push(16'($urandom));
    fill_color = 16'h07E0;
    fill_start = 1'b1;
    @(negedge clk_16MHz);
    fill_start = 1'b0;
    drv_hold   = 0;
    emit_home();
    for (int i = 0; i < FramePix; i++) begin
      exp_q.push_back({2'b00, 16'h07E0});
      emit_done_if_wrap();
    end
    t = 0;
    while (obs_q.size() < 6 && t < 500) begin
      @(negedge clk_16MHz);
      t++;
    end
    chk("fill in_time", 32'(t < 500), 1);
    chk("fill level kept", fifo_level, 2);
    drain("fill");
`endif

    // Reset while a request is outstanding, FIFO full and overflow set.
    drv_mute = 1;
    for (int i = 0; i < 17; i++) push(16'($urandom));
    chk("prerst pix_clk", pix_clk, 1);
    chk("prerst full", fifo_full, 1);
    chk("prerst ovf", overflow, 1);
    reset = 1'b1;
    @(negedge clk_16MHz);
    reset = 1'b0;
    chk("midrst pix_clk", pix_clk, 0);
    chk("midrst level", fifo_level, 0);
    chk("midrst overflow", overflow, 0);
    chk("midrst full", fifo_full, 0);
    m_fifo.delete();
    m_cnt    = 0;
    drv_mute = 0;
    obs_q.delete();
    for (int i = 0; i < 5; i++) push(16'($urandom));
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Write while full and clear in the same cycle.
  task automatic overflow_clear_race();
    wr_en        = 1'b1;
    wr_data      = 16'hBEEF;
    clr_overflow = 1'b1;
    @(negedge clk_16MHz);
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
  endtask

endmodule
